// File: rtl/tff_toggle_ctrl.sv
// tff_toggle_ctrl: conditions a raw, bouncing push-button into a clean
// single-cycle T pulse for a toggle flip-flop, and counts accepted presses.
// Optional feature macro: TOGGLE_AUTOREPEAT_EN (auto-repeat T while held).
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   IDLE       | button released and settled, waiting for a high sample
//   DB_PRESS   | high seen, counting stable high samples before accepting
//   HELD       | press accepted (T issued), waiting for a low sample
//   DB_RELEASE | low seen, counting stable low samples before releasing
module tff_toggle_ctrl #(
   parameter int unsigned DB_CYCLES     = 4,
   parameter int unsigned REPEAT_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_IN,
   output logic       T,
   output logic       BUSY,
   output logic [7:0] PRESS_COUNT
);

   if (DB_CYCLES < 2 || DB_CYCLES > 255 ||
       REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
      $error("tff_toggle_ctrl: DB_CYCLES or REPEAT_CYCLES out of range");
   end

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       sync0_q, sync1_q;
   logic       t_q, t_d;
   logic       busy_q, busy_d;
   logic [7:0] press_count_q, press_count_d;

`ifdef TOGGLE_AUTOREPEAT_EN
   localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);
   logic [15:0] rpt_q, rpt_d;

   // Repeat interval counter; only meaningful while in HELD.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) rpt_q <= '0;
      else     rpt_q <= rpt_d;
   end
`endif

   // Two-flop synchroniser for the asynchronous button level.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
      end else begin
         sync0_q <= BTN_IN;
         sync1_q <= sync0_q;
      end
   end

   // State, debounce counter and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         t_q           <= 1'b0;
         busy_q        <= 1'b0;
         press_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         t_q           <= t_d;
         busy_q        <= busy_d;
         press_count_q <= press_count_d;
      end
   end

   // Next-state, debounce counting and pulse generation.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      t_d           = 1'b0;
      press_count_d = press_count_q;
`ifdef TOGGLE_AUTOREPEAT_EN
      rpt_d         = rpt_q;
`endif
      case (state_q)
         IDLE: begin
            if (sync1_q) begin
               state_d = DB_PRESS;
               cnt_d   = '0;
            end
         end
         DB_PRESS: begin
            if (!sync1_q) begin
               state_d = IDLE;
            end else if (cnt_q == DB_LAST) begin
               state_d       = HELD;
               t_d           = 1'b1;
               press_count_d = press_count_q + 8'd1;
`ifdef TOGGLE_AUTOREPEAT_EN
               rpt_d         = '0;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HELD: begin
            if (!sync1_q) begin
               state_d = DB_RELEASE;
               cnt_d   = '0;
`ifdef TOGGLE_AUTOREPEAT_EN
               rpt_d   = '0;
            end else if (rpt_q == RPT_LAST) begin
               t_d           = 1'b1;
               press_count_d = press_count_q + 8'd1;
               rpt_d         = '0;
            end else begin
               rpt_d = rpt_q + 16'd1;
`endif
            end
         end
         DB_RELEASE: begin
            // A high sample here is release bounce: back to HELD, no new pulse.
            if (sync1_q) begin
               state_d = HELD;
`ifdef TOGGLE_AUTOREPEAT_EN
               rpt_d   = '0;
`endif
            end else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign T           = t_q;
   assign BUSY        = busy_q;
   assign PRESS_COUNT = press_count_q;

endmodule

// File: tb/tb_tff_toggle_ctrl.sv
// Bench for tff_toggle_ctrl: run-length reference model feeding a pulse
// scoreboard, plus directed latency / wrap / reset checks.
module tb_tff_toggle_ctrl;

   localparam int DB  = 4;
   localparam int RPT = 16;
`ifdef TOGGLE_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BTN_IN = 1'b0;
   logic       T, BUSY;
   logic [7:0] PRESS_COUNT;

   always #5 CLK = ~CLK;

   tff_toggle_ctrl #(.DB_CYCLES(DB), .REPEAT_CYCLES(RPT)) dut (
      .CLK(CLK), .RST(RST), .BTN_IN(BTN_IN),
      .T(T), .BUSY(BUSY), .PRESS_COUNT(PRESS_COUNT)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int unsigned e_idx;
      logic [7:0]  cnt;
   } exp_t;
   exp_t sb[$];

   // Reference model: the FSM sees BTN_IN two edges late; a press is accepted
   // after DB+1 consecutive high samples, a release after DB+1 consecutive
   // low samples; auto-repeat fires every RPT uninterrupted high samples.
   int unsigned edge_cnt = 0;
   bit          b1, b2, s, pressed, pulse, exp_busy;
   int          run1, run0, held_len;
   logic [7:0]  exp_count;

   initial forever begin
      @(posedge CLK);
      edge_cnt++;
      if (RST) begin
         b1 = 0; b2 = 0; pressed = 0; run1 = 0; run0 = 0; held_len = 0;
         exp_count = 8'd0; exp_busy = 0;
      end else begin
         s = b2; b2 = b1; b1 = BTN_IN; pulse = 0;
         if (!pressed) begin
            run1 = s ? run1 + 1 : 0;
            if (run1 == DB + 1) begin
               pressed = 1; run0 = 0; held_len = 0; pulse = 1;
            end
         end else if (s) begin
            if (run0 > 0) begin
               run0 = 0; held_len = 0;
            end else begin
               held_len++;
               if (AR && (held_len % RPT) == 0) pulse = 1;
            end
         end else begin
            run0++;
            if (run0 == DB + 1) begin
               pressed = 0; run1 = 0;
            end
         end
         exp_busy = pressed || (run1 > 0);
         if (pulse) begin
            exp_count = exp_count + 8'd1;
            sb.push_back('{e_idx: edge_cnt, cnt: exp_count});
         end
      end
   end

   // Monitor: pops the scoreboard whenever T is presented.
   bit          tff_q = 0, busy_prev = 0;
   int unsigned t_seen = 0, last_t_edge = 0, last_rise = 0, last_fall = 0;
   exp_t        e;

   initial forever begin
      @(posedge CLK);
      #2;
      if (T === 1'b1) begin
         tff_q = ~tff_q;
         t_seen++;
         last_t_edge = edge_cnt;
         if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL t_unexpected: T=1 at edge %0d, expected no pulse", edge_cnt);
         end else begin
            e = sb.pop_front();
            chk("t_edge", edge_cnt, e.e_idx);
            chk("t_count", {24'd0, PRESS_COUNT}, {24'd0, e.cnt});
         end
      end else if (sb.size() != 0 && sb[0].e_idx <= edge_cnt) begin
         e = sb.pop_front();
         n_checks++; n_fail++;
         $display("FAIL t_missing: T=0 at edge %0d, expected pulse at edge %0d", edge_cnt, e.e_idx);
      end
      chk("busy", {31'd0, BUSY}, {31'd0, exp_busy});
      chk("press_count", {24'd0, PRESS_COUNT}, {24'd0, exp_count});
      if (BUSY === 1'b1 && !busy_prev) last_rise = edge_cnt;
      if (BUSY === 1'b0 && busy_prev)  last_fall = edge_cnt;
      busy_prev = (BUSY === 1'b1);
   end

   task automatic drive(input bit v, input int n);
      repeat (n) begin
         @(negedge CLK);
         BTN_IN = v;
      end
   endtask

   task automatic press(input int hi, input int lo, output int unsigned k, output int unsigned m);
      @(negedge CLK);
      k = edge_cnt + 1;
      BTN_IN = 1'b1;
      repeat (hi - 1) @(negedge CLK);
      @(negedge CLK);
      m = edge_cnt + 1;
      BTN_IN = 1'b0;
      repeat (lo - 1) @(negedge CLK);
   endtask

   int unsigned k, m, r, t0;
   bit          tff_before;

   initial begin
      // Reset held with the button toggling.
      RST = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         BTN_IN = ~BTN_IN;
      end
      @(negedge CLK);
      RST = 1'b0;
      BTN_IN = 1'b0;
      repeat (10) @(negedge CLK);
      chk("idle_count", {24'd0, PRESS_COUNT}, 32'd0);
      chk("idle_busy", {31'd0, BUSY}, 32'd0);
      chk("idle_pulses", t_seen, 32'd0);

      // Clean press: latency of BUSY rise, T, and BUSY fall.
      press(20, 12, k, m);
      chk("busy_rise_latency", last_rise, k + 2);
      chk("t_latency", last_t_edge, k + 2 + DB);
      chk("busy_fall_latency", last_fall, m + 2 + DB);
      chk("clean_count", {24'd0, PRESS_COUNT}, 32'd1);

      // Short glitch, then a press with bounce on release.
      press(3, 10, k, m);
      chk("glitch_count", {24'd0, PRESS_COUNT}, 32'd1);
      chk("glitch_busy", {31'd0, BUSY}, 32'd0);
      drive(1, 20); drive(0, 2); drive(1, 3); drive(0, 12);
      chk("bounce_count", {24'd0, PRESS_COUNT}, 32'd2);

      // 256 presses: count wraps back, driven TFF returns to its start value.
      t0 = t_seen;
      tff_before = tff_q;
      repeat (256) press($urandom_range(6, 10), $urandom_range(7, 10), k, m);
      chk("wrap_pulses", t_seen - t0, 32'd256);
      chk("wrap_count", {24'd0, PRESS_COUNT}, 32'd2);
      chk("tff_parity", {31'd0, tff_q}, {31'd0, tff_before});

      // Reset during DB_PRESS with the button still high.
      t0 = t_seen;
      @(negedge CLK);
      k = edge_cnt + 1;
      BTN_IN = 1'b1;
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      r = edge_cnt + 1;
      chk("rst_mid_count", {24'd0, PRESS_COUNT}, 32'd0);
      drive(1, 20); drive(0, 12);
      chk("rst_mid_pulses", t_seen - t0, 32'd1);
      chk("rst_mid_latency", last_t_edge, r + 2 + DB);
      chk("rst_mid_count_after", {24'd0, PRESS_COUNT}, 32'd1);

      // Long hold: auto-repeat pulses only when the feature is built in.
      t0 = t_seen;
      press(DB + 2 + 40, 12, k, m);
      chk("hold_pulses", t_seen - t0, AR ? 32'd3 : 32'd1);
      chk("hold_count", {24'd0, PRESS_COUNT}, AR ? 32'd4 : 32'd2);

      // Random bouncing traffic against the model.
      repeat (400) drive($urandom_range(0, 1), $urandom_range(1, 9));
      drive(0, 20);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
